mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-port unified instruction/data memory between the IF stage (fetch) and the MEM stage (load/store).
//  Serialises accesses, drives the memory port, returns read data and acks, and raises per-stage stall requests.
//  Sits between the pipeline stages and the memory macro, in the same clock domain as the pipeline.
// PARAMETERS
//  ADDR_W     32  address width, in bits
//  DATA_W     32  data width, in bits; wstrb width is DATA_W/8
//  MEM_LAT    2   cycles from mem_en to valid mem_rdata; legal range 1..7
//  STARVE_MAX 4   consecutive fetch losses before fetch is forced; used only with MEM_ARB_STARVE_GUARD_EN
// PORTS
//  clk        in   1         pipeline clock; all state changes on the rising edge
//  rst        in   1         synchronous reset, active-high
//  if_req     in   1         fetch request; held high with if_addr stable until if_ack
//  if_addr    in   ADDR_W    fetch address
//  if_rdata   out  DATA_W    fetch data; valid only while if_ack=1
//  if_ack     out  1         one-cycle fetch completion pulse
//  dm_req     in   1         data request; held high with all dm_* inputs stable until dm_ack
//  dm_we      in   1         1 = store, 0 = load
//  dm_addr    in   ADDR_W    data address
//  dm_wdata   in   DATA_W    store data
//  dm_wstrb   in   DATA_W/8  store byte enables
//  dm_rdata   out  DATA_W    load data; valid only while dm_ack=1
//  dm_ack     out  1         one-cycle data completion pulse (loads and stores)
//  mem_en     out  1         memory access strobe, one cycle per access
//  mem_we     out  1         memory write enable
//  mem_addr   out  ADDR_W    memory address
//  mem_wdata  out  DATA_W    memory write data
//  mem_wstrb  out  DATA_W/8  memory byte enables
//  mem_rdata  in   DATA_W    memory read data
//  stall_if   out  1         if_req & ~if_ack (combinational)
//  stall_mem  out  1         dm_req & ~dm_ack (combinational)
// BEHAVIOUR
//  - FSM states: IDLE, IF_ACC, DM_ACC. Latency counter cnt is 3 bits.
//  - IDLE:
//    - dm_req=1 -> DM_ACC (data has priority); else if_req=1 -> IF_ACC; else stay in IDLE.
//    - On the grant edge, the mem_* output registers load the request fields and cnt clears to 0.
//  - First ACC cycle: mem_en=1, for one cycle only.
//    - IF_ACC forces mem_we=0 and mem_wstrb=0.
//    - DM_ACC drives mem_we=dm_we. mem_wstrb=dm_wstrb for stores, 0 for loads.
//  - In ACC states cnt increments each cycle. When cnt==MEM_LAT:
//    - the granted ack=1 and its rdata = mem_rdata (combinational pass-through);
//    - next state is IDLE.
//  - One mandatory IDLE turnaround cycle follows every ack.
//    - Request-to-ack latency is MEM_LAT+1 cycles; peak throughput is 1 access per MEM_LAT+2 cycles.
//  - mem_addr, mem_wdata and mem_wstrb hold their last values outside mem_en. The non-granted ack is always 0.
//  - Both requests in the same IDLE cycle: data wins; fetch is granted at the next IDLE.
//  - Requester drops req before its ack (protocol violation): the access still completes and the ack still pulses.
//  - rst=1 at any time, including mid-access: state=IDLE, cnt=0, every output register cleared to 0.
//    - The in-flight access is abandoned and no ack is issued.
//  - Reset values: if_ack, dm_ack, mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb are 0.
//    - if_rdata and dm_rdata are 0 (gated by ack).
//    - stall_* follow the req inputs.
// CONFIGURATION
//  - MEM_ARB_STARVE_GUARD_EN defined:
//    - a 3-bit starve counter increments on each IDLE grant to data while if_req=1;
//    - it clears on any fetch grant;
//    - when the counter reaches STARVE_MAX, the next IDLE grant goes to fetch even if dm_req=1.
//  - MEM_ARB_STARVE_GUARD_EN undefined: strict data priority, and no starve counter is instantiated.
// STRUCTURE
//  - Shared package riscv_pkg holds:
//    - ARB_IDLE=2'b00, ARB_IF=2'b01, ARB_DM=2'b10;
//    - default MEM_LAT and STARVE_MAX.
//  - One sub-module: arb_lat_counter.
//    - Inputs: clr, en. Output: done (cnt==MEM_LAT).
//    - Reused by a future multi-cycle multiply/divide unit.
//  - FSM, grant logic and output registers stay in mem_port_arbiter.
// TESTING (MEM_LAT=2)
//  - Single fetch: if_req=1, if_addr=0x100 at cycle 0, mem returns 0x00500093.
//    - Expect mem_en at cycle 1, if_ack=1 and if_rdata=0x00500093 at cycle 3, stall_if high during cycles 0..2.
//  - Store: dm_req=1, dm_we=1, dm_addr=0x2004, dm_wdata=0xDEADBEEF, dm_wstrb=4'b0011.
//    - Expect mem_we=1, mem_wstrb=4'b0011 with mem_en, then dm_ack 2 cycles later.
//    - Expect if_ack=0 throughout.
//  - Collision: if_req and dm_req both rise at cycle 0.
//    - Expect dm_ack at cycle 3, IDLE at cycle 4, fetch mem_en at cycle 5, if_ack at cycle 7.
//  - Reset mid-access: rst=1 in the cycle after mem_en.
//    - Expect no ack, all outputs 0 next cycle, and a held request regranted 1 cycle after rst falls.
//  - Starvation, guard on: dm_req held continuously for 5 loads with if_req=1.
//    - Expect fetch granted after the 4th load.
//    - Guard off: fetch is never granted while dm_req=1.
//  - Early drop: dm_req deasserted in the cycle after grant. Expect dm_ack still pulses at cnt==2.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared pipeline package: memory-arbiter state encoding, default timing
// parameters and a small saturating-counter helper.
package riscv_pkg;

    // Arbiter FSM encoding; the values are visible to other pipeline logic.
    typedef enum logic [1:0] {
        ARB_IDLE = 2'b00,
        ARB_IF   = 2'b01,
        ARB_DM   = 2'b10
    } arb_state_t;

    // Width of the latency and starve counters.
    localparam int ARB_CNT_W = 3;

    // Default cycles from mem_en to valid mem_rdata (legal 1..7).
    localparam int ARB_MEM_LAT_DEF = 2;

    // Default consecutive fetch losses before fetch is forced.
    localparam int ARB_STARVE_MAX_DEF = 4;

    // Increment v by one, but never past lim.
    function automatic logic [ARB_CNT_W-1:0] arb_sat_inc(
        input logic [ARB_CNT_W-1:0] v,
        input logic [ARB_CNT_W-1:0] lim
    );
        return (v >= lim) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/arb_lat_counter.sv
// Fixed-latency wait counter. clr restarts the count at 0, en advances it,
// done flags that the count has reached MEM_LAT. Kept generic so other
// multi-cycle units can share it.
module arb_lat_counter
    import riscv_pkg::*;
#(
    parameter int MEM_LAT = ARB_MEM_LAT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic done
);

    logic [ARB_CNT_W-1:0] cnt_reg;

    // Count cycles since the last clear; saturate at MEM_LAT.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg <= '0;
        end else if (clr) begin
            cnt_reg <= '0;
        end else if (en) begin
            cnt_reg <= arb_sat_inc(cnt_reg, ARB_CNT_W'(MEM_LAT));
        end
    end

    assign done = (cnt_reg == ARB_CNT_W'(MEM_LAT));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port unified memory between the fetch stage
// and the load/store stage. Data requests win over fetch; each access is
// one mem_en pulse, a MEM_LAT wait, a one-cycle ack and one IDLE
// turnaround cycle.
// Optional build macro MEM_ARB_STARVE_GUARD_EN: after STARVE_MAX data
// grants taken while fetch was waiting, the next grant goes to fetch.
module mem_port_arbiter
    import riscv_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = ARB_MEM_LAT_DEF,
    parameter int STARVE_MAX = ARB_STARVE_MAX_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req,
    input  logic [ADDR_W-1:0]     if_addr,
    output logic [DATA_W-1:0]     if_rdata,
    output logic                  if_ack,
    input  logic                  dm_req,
    input  logic                  dm_we,
    input  logic [ADDR_W-1:0]     dm_addr,
    input  logic [DATA_W-1:0]     dm_wdata,
    input  logic [DATA_W/8-1:0]   dm_wstrb,
    output logic [DATA_W-1:0]     dm_rdata,
    output logic                  dm_ack,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W/8-1:0]   mem_wstrb,
    input  logic [DATA_W-1:0]     mem_rdata,
    output logic                  stall_if,
    output logic                  stall_mem
);

    localparam int STRB_W = DATA_W / 8;

    // Reject out-of-range timing parameters at elaboration.
    if (MEM_LAT < 1 || MEM_LAT > 7 || STARVE_MAX < 1 || STARVE_MAX > 7) begin : g_param_check
        $error("mem_port_arbiter: MEM_LAT and STARVE_MAX must be in 1..7");
    end

    arb_state_t          state_reg;
    logic                mem_en_reg;
    logic                mem_we_reg;
    logic [ADDR_W-1:0]   mem_addr_reg;
    logic [DATA_W-1:0]   mem_wdata_reg;
    logic [STRB_W-1:0]   mem_wstrb_reg;

    logic                in_idle;
    logic                grant_dm;
    logic                grant_if;
    logic                force_if;
    logic                lat_done;
    logic                lat_en;

    assign in_idle = (state_reg == ARB_IDLE);

`ifdef MEM_ARB_STARVE_GUARD_EN
    logic [ARB_CNT_W-1:0] starve_reg;

    // Track data grants that overtook a waiting fetch; any fetch grant clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_reg <= '0;
        end else if (grant_if) begin
            starve_reg <= '0;
        end else if (grant_dm && if_req) begin
            starve_reg <= arb_sat_inc(starve_reg, ARB_CNT_W'(STARVE_MAX));
        end
    end

    assign force_if = if_req && (starve_reg >= ARB_CNT_W'(STARVE_MAX));
`else
    assign force_if = 1'b0;
`endif

    // Data has priority unless the starve guard is forcing a fetch.
    assign grant_dm = in_idle && dm_req && !force_if;
    assign grant_if = in_idle && if_req && !grant_dm;

    // Latency counter runs only while an access is in flight.
    assign lat_en = !in_idle && !lat_done;

    arb_lat_counter #(
        .MEM_LAT (MEM_LAT)
    ) u_lat_counter (
        .clk  (clk),
        .rst  (rst),
        .clr  (grant_dm || grant_if),
        .en   (lat_en),
        .done (lat_done)
    );

    // Arbiter FSM and memory-port output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ARB_IDLE;
            mem_en_reg    <= 1'b0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            mem_wstrb_reg <= '0;
        end else begin
            // mem_en and mem_we are single-cycle strobes; address/data/strobes hold.
            mem_en_reg <= 1'b0;
            mem_we_reg <= 1'b0;
            case (state_reg)
                ARB_IDLE: begin
                    if (grant_dm) begin
                        state_reg     <= ARB_DM;
                        mem_en_reg    <= 1'b1;
                        mem_we_reg    <= dm_we;
                        mem_addr_reg  <= dm_addr;
                        mem_wdata_reg <= dm_wdata;
                        mem_wstrb_reg <= dm_we ? dm_wstrb : '0;
                    end else if (grant_if) begin
                        state_reg     <= ARB_IF;
                        mem_en_reg    <= 1'b1;
                        mem_addr_reg  <= if_addr;
                        mem_wstrb_reg <= '0;
                    end
                end
                ARB_IF, ARB_DM: begin
                    if (lat_done) begin
                        state_reg <= ARB_IDLE;
                    end
                end
                default: begin
                    state_reg <= ARB_IDLE;
                end
            endcase
        end
    end

    // Ack in the cycle the counter reaches MEM_LAT; an access caught by
    // reset is abandoned, so the ack is suppressed while rst is high.
    assign if_ack = !rst && (state_reg == ARB_IF) && lat_done;
    assign dm_ack = !rst && (state_reg == ARB_DM) && lat_done;

    assign if_rdata = if_ack ? mem_rdata : '0;
    assign dm_rdata = dm_ack ? mem_rdata : '0;

    assign stall_if  = if_req && !if_ack;
    assign stall_mem = dm_req && !dm_ack;

    assign mem_en    = mem_en_reg;
    assign mem_we    = mem_we_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;
    assign mem_wstrb = mem_wstrb_reg;

endmodule
